// File: rtl/time_keeper_pkg.sv
// Shared definitions for the time-of-day keeper: mode encoding, BCD limits and tap index width.
package time_keeper_pkg;

  typedef enum logic [1:0] {
    ModeRun    = 2'b00,
    ModeSetHr  = 2'b01,
    ModeSetMin = 2'b10
  } mode_e;

  localparam logic [7:0] BcdMaxSec = 8'h59;
  localparam logic [7:0] BcdMaxMin = 8'h59;
  localparam logic [7:0] BcdMaxHr  = 8'h23;

  localparam int unsigned TapW = 4;

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps from MAX_BCD to 00, flagging a carry on the wrapping increment.
module bcd_mod_counter
  import time_keeper_pkg::*;
#(
  parameter logic [7:0] MAX_BCD = BcdMaxSec
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_inc,
  input  logic       i_clear,
  output logic [7:0] o_value,
  output logic       o_carry
);

  logic [7:0] r_value;
  logic [7:0] w_value_next;

  assign o_carry = i_inc & ~i_clear & (r_value == MAX_BCD);
  assign o_value = r_value;

  always_comb begin
    w_value_next = r_value;
    if (i_clear) begin
      w_value_next = 8'h00;
    end else if (i_inc) begin
      if (r_value == MAX_BCD) begin
        w_value_next = 8'h00;
      end else if (r_value[3:0] == 4'd9) begin
        w_value_next = {r_value[7:4] + 4'd1, 4'd0};
      end else begin
        w_value_next = {r_value[7:4], r_value[3:0] + 4'd1};
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_value <= 8'h00;
    end else begin
      r_value <= w_value_next;
    end
  end

endmodule

// File: rtl/time_keeper.sv
// Turns a selected divider tap into a seconds tick and keeps a settable 24-hour BCD time of day.
module time_keeper
  import time_keeper_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 381,
  parameter int unsigned DEFAULT_TAP   = 0
) (
  input  logic            clk,
  input  logic            RESETn,
  input  logic [15:0]     clk_div_in,
  input  logic [TapW-1:0] tap_sel,
  input  logic            mode_pulse,
  input  logic            inc_pulse,
  output logic [7:0]      hr_bcd,
  output logic [7:0]      min_bcd,
  output logic [7:0]      sec_bcd,
  output logic [1:0]      mode,
  output logic            sec_tick
);

  localparam int unsigned PreW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(TICKS_PER_SEC - 1);

  mode_e           r_mode, w_mode_next;
  logic [TapW-1:0] r_tap_sel;
  logic            r_tap_q;
  logic [PreW-1:0] r_pre, w_pre_next;
  logic            r_sec_tick, w_tick_next;

  logic w_tap_now, w_edge, w_run_tick, w_enter_set;
  logic w_sec_carry, w_min_carry, w_hr_carry;
  logic w_sec_inc, w_min_inc, w_hr_inc;

  // A tap switch masks the edge so the mux change itself never counts as a rising edge.
  assign w_tap_now = clk_div_in[tap_sel];
  assign w_edge    = w_tap_now & ~r_tap_q & (tap_sel == r_tap_sel);

  assign w_enter_set = (r_mode == ModeRun) & mode_pulse;
  // A tick landing on the RUN -> SET_HR transition is dropped entirely, carries included.
  assign w_run_tick  = r_sec_tick & (r_mode == ModeRun) & ~mode_pulse;

  always_comb begin
    w_mode_next = r_mode;
    case (r_mode)
      ModeRun:    if (mode_pulse) w_mode_next = ModeSetHr;
      ModeSetHr:  if (mode_pulse) w_mode_next = ModeSetMin;
      ModeSetMin: if (mode_pulse) w_mode_next = ModeRun;
      default:    w_mode_next = ModeRun;
    endcase
  end

  always_comb begin
    w_pre_next  = r_pre;
    w_tick_next = 1'b0;
    if ((r_mode != ModeRun) || mode_pulse) begin
      w_pre_next = '0;
    end else if (w_edge) begin
      if (r_pre == PreMax) begin
        w_pre_next  = '0;
        w_tick_next = 1'b1;
      end else begin
        w_pre_next = r_pre + PreW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      r_mode     <= ModeRun;
      r_tap_sel  <= TapW'(DEFAULT_TAP);
      r_tap_q    <= 1'b0;
      r_pre      <= '0;
      r_sec_tick <= 1'b0;
    end else begin
      r_mode     <= w_mode_next;
      r_tap_sel  <= tap_sel;
      r_tap_q    <= w_tap_now;
      r_pre      <= w_pre_next;
      r_sec_tick <= w_tick_next;
    end
  end

  assign w_sec_inc = w_run_tick;
  assign w_min_inc = (w_run_tick & w_sec_carry) |
                     ((r_mode == ModeSetMin) & inc_pulse & ~mode_pulse);
  assign w_hr_inc  = (w_run_tick & w_sec_carry & w_min_carry) |
                     ((r_mode == ModeSetHr) & inc_pulse & ~mode_pulse);

  bcd_mod_counter #(.MAX_BCD(BcdMaxSec)) u_sec (
    .i_clk   (clk),
    .i_rst_n (RESETn),
    .i_inc   (w_sec_inc),
    .i_clear (w_enter_set),
    .o_value (sec_bcd),
    .o_carry (w_sec_carry)
  );

  bcd_mod_counter #(.MAX_BCD(BcdMaxMin)) u_min (
    .i_clk   (clk),
    .i_rst_n (RESETn),
    .i_inc   (w_min_inc),
    .i_clear (1'b0),
    .o_value (min_bcd),
    .o_carry (w_min_carry)
  );

  // Hour carry has no consumer; the day simply wraps.
  bcd_mod_counter #(.MAX_BCD(BcdMaxHr)) u_hr (
    .i_clk   (clk),
    .i_rst_n (RESETn),
    .i_inc   (w_hr_inc),
    .i_clear (1'b0),
    .o_value (hr_bcd),
    .o_carry (w_hr_carry)
  );

  assign mode     = r_mode;
  assign sec_tick = r_sec_tick;

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: directed scenarios plus random bus/button traffic against a seconds-of-day model.
module tb_time_keeper;

  localparam int unsigned TPS = 4;

  logic        clk = 1'b0;
  logic        RESETn;
  logic [15:0] clk_div_in;
  logic [3:0]  tap_sel;
  logic        mode_pulse, inc_pulse;
  logic [7:0]  hr_bcd, min_bcd, sec_bcd;
  logic [1:0]  mode;
  logic        sec_tick;

  always #5 clk = ~clk;

  time_keeper #(.TICKS_PER_SEC(TPS), .DEFAULT_TAP(0)) dut (
    .clk        (clk),
    .RESETn     (RESETn),
    .clk_div_in (clk_div_in),
    .tap_sel    (tap_sel),
    .mode_pulse (mode_pulse),
    .inc_pulse  (inc_pulse),
    .hr_bcd     (hr_bcd),
    .min_bcd    (min_bcd),
    .sec_bcd    (sec_bcd),
    .mode       (mode),
    .sec_tick   (sec_tick)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: time as seconds since midnight, mode as 0/1/2.
  int m_tod, m_mode, m_pre;
  bit m_tick, m_prev_bit;
  int m_prev_sel;

  int          bus_mode;  // 0 fast divider model, 1 random, 2 manual
  logic [17:0] div_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic bit bcd_ok(input logic [7:0] v, input logic [7:0] lim);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= lim);
  endfunction

  task automatic reset_model();
    m_tod = 0; m_mode = 0; m_pre = 0; m_tick = 0; m_prev_bit = 0; m_prev_sel = 0;
  endtask

  task automatic model_step();
    bit cur, edge_seen;
    int mm;
    cur        = clk_div_in[tap_sel];
    edge_seen  = (int'(tap_sel) == m_prev_sel) && cur && !m_prev_bit;
    m_prev_bit = cur;
    m_prev_sel = int'(tap_sel);
    case (m_mode)
      0: begin
        if (mode_pulse) begin
          m_mode = 1; m_tod = m_tod - (m_tod % 60); m_pre = 0; m_tick = 0;
        end else begin
          if (m_tick) m_tod = (m_tod + 1) % 86400;
          m_tick = 0;
          if (edge_seen) begin
            m_pre++;
            if (m_pre == TPS) begin m_pre = 0; m_tick = 1; end
          end
        end
      end
      1: begin
        if (mode_pulse) m_mode = 2;
        else if (inc_pulse) m_tod = (m_tod + 3600) % 86400;
      end
      default: begin
        if (mode_pulse) m_mode = 0;
        else if (inc_pulse) begin
          mm = (m_tod / 60) % 60;
          m_tod = m_tod - mm * 60 + ((mm + 1) % 60) * 60;
        end
      end
    endcase
  endtask

  task automatic check_outputs();
    chk("hr",  hr_bcd,  to_bcd(m_tod / 3600));
    chk("min", min_bcd, to_bcd((m_tod / 60) % 60));
    chk("sec", sec_bcd, to_bcd(m_tod % 60));
    chk("mode", mode, m_mode);
    chk("sec_tick", sec_tick, m_tick);
    chk("bcd_legal", {31'd0, bcd_ok(hr_bcd, 8'h23) && bcd_ok(min_bcd, 8'h59) &&
                     bcd_ok(sec_bcd, 8'h59)}, 1);
  endtask

  task automatic run_cycle(input bit mp, input bit ip);
    mode_pulse = mp;
    inc_pulse  = ip;
    if (bus_mode == 0) begin
      clk_div_in = div_cnt[16:1];
      div_cnt++;
    end else if (bus_mode == 1) begin
      clk_div_in = 16'($urandom);
    end
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
    mode_pulse = 1'b0;
    inc_pulse  = 1'b0;
  endtask

  // Called at posedge+1; reset asserts away from the edge and releases one edge later.
  task automatic apply_reset();
    RESETn = 1'b0;
    reset_model();
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    RESETn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  bound, ticks, hr0, min0, sec0;
    bit  seen;
    RESETn = 1'b0; tap_sel = 4'd0; mode_pulse = 0; inc_pulse = 0;
    clk_div_in = 16'h0; div_cnt = '0; bus_mode = 0;
    reset_model();
    #2;
    check_outputs();
    @(posedge clk);
    #1;
    RESETn = 1'b1;

    // First second from tap 0 of the divider model.
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      run_cycle(0, 0);
      seen = sec_tick;
    end
    chk("first_tick_seen", seen, 1);
    run_cycle(0, 0);
    chk("first_second", sec_bcd, 8'h01);

    // Preload 23:59 and run through midnight.
    run_cycle(1, 0);
    for (int i = 0; i < 23; i++) run_cycle(0, 1);
    run_cycle(1, 0);
    for (int i = 0; i < 59; i++) run_cycle(0, 1);
    run_cycle(1, 0);
    chk("preload", {8'h0, hr_bcd, min_bcd, sec_bcd}, 32'h00235900);
    bound = 0;
    while (m_tod != 0 && bound < 1500) begin
      run_cycle(0, 0);
      bound++;
    end
    chk("midnight_reached", {31'd0, bound < 1500}, 1);
    chk("midnight", {8'h0, hr_bcd, min_bcd, sec_bcd}, 32'h0);

    // Set sequence: 5 hour incs, 61 minute incs.
    apply_reset();
    run_cycle(1, 0);
    chk("mode_sethr", mode, 2'b01);
    for (int i = 0; i < 5; i++) run_cycle(0, 1);
    run_cycle(1, 0);
    chk("mode_setmin", mode, 2'b10);
    for (int i = 0; i < 61; i++) run_cycle(0, 1);
    run_cycle(1, 0);
    chk("mode_run", mode, 2'b00);
    chk("set_result", {8'h0, hr_bcd, min_bcd, sec_bcd}, 32'h00050100);

    // Tap switch 0 -> 3 while tap 3 is already high must not count.
    bus_mode = 2;
    clk_div_in = 16'h0000;
    run_cycle(0, 0);
    run_cycle(0, 0);
    clk_div_in = 16'h0008;
    tap_sel = 4'd3;
    ticks = 0;
    for (int i = 0; i < 3; i++) begin run_cycle(0, 0); ticks += int'(sec_tick); end
    for (int i = 0; i < 3; i++) begin
      clk_div_in = 16'h0000; run_cycle(0, 0); ticks += int'(sec_tick);
      clk_div_in = 16'h0008; run_cycle(0, 0); ticks += int'(sec_tick);
    end
    chk("tap_switch_no_tick", ticks, 0);
    clk_div_in = 16'h0000; run_cycle(0, 0); ticks += int'(sec_tick);
    clk_div_in = 16'h0008; run_cycle(0, 0); ticks += int'(sec_tick);
    chk("tap_switch_fourth_edge", ticks, 1);

    // Simultaneous mode+inc in RUN, then inc alone in RUN.
    run_cycle(0, 0);
    hr0 = int'(hr_bcd);
    run_cycle(1, 1);
    chk("simul_mode", mode, 2'b01);
    chk("simul_hr", hr_bcd, hr0);
    run_cycle(1, 0);
    run_cycle(1, 0);
    hr0 = int'(hr_bcd); min0 = int'(min_bcd); sec0 = int'(sec_bcd);
    run_cycle(0, 1);
    chk("run_inc_ignored", {8'h0, hr_bcd, min_bcd, sec_bcd}, {8'h0, 8'(hr0), 8'(min0), 8'(sec0)});

    // Asynchronous reset while in SET_MIN at 12:34.
    tap_sel = 4'd0;
    bus_mode = 0;
    apply_reset();
    run_cycle(1, 0);
    for (int i = 0; i < 12; i++) run_cycle(0, 1);
    run_cycle(1, 0);
    for (int i = 0; i < 34; i++) run_cycle(0, 1);
    chk("pre_async", {8'h0, hr_bcd, min_bcd, 6'd0, mode}, 32'h00123402);
    #2;
    RESETn = 1'b0;
    reset_model();
    #1;
    chk("async_time", {8'h0, hr_bcd, min_bcd, sec_bcd}, 32'h0);
    chk("async_mode", mode, 2'b00);
    check_outputs();
    @(posedge clk);
    #1;
    RESETn = 1'b1;

    // Random bus, tap and button traffic.
    bus_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 31) == 0) tap_sel = 4'($urandom_range(0, 15));
      run_cycle($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
